// File: rtl/program_counter_pkg.sv
// Shared CPU configuration: default widths and the program-counter state type.
package cpuConfig;

    // Default program-address width.
    localparam int P_SIZE = 6;
    // Default data-memory address width.
    localparam int A_SIZE = 6;
    // Default opcode width.
    localparam int O_SIZE = 4;

    // Program-counter sequencing states.
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } pcState_t;

    // Observation bundle: FSM state plus the qualified switch signals.
    typedef struct packed {
        pcState_t state;
        logic     sw_level;
        logic     sw_rise;
    } pc_debug_t;

endpackage

// File: rtl/switch_sync.sv
// Two-flop synchroniser plus history flop for a raw board switch.
// level is the synchronised switch; rise pulses for one cycle on a 0->1 change.
module switch_sync (
    input  logic clk,
    input  logic nReset,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic hist;

    // Shift the raw switch through the synchroniser and the history flop.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            hist <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~hist;

endmodule

// File: rtl/program_counter.sv
// Program counter with a RUN/STALL sequencer. A stall is released by the decoder
// advancing, and the decoder is told to advance by a qualified switch press.
// Optional feature macro: PC_BRANCH_EN adds branchEn/branchOffset and a
// relative-branch adder (taken only when the decoder advances).
module program_counter #(
    parameter int P_SIZE = cpuConfig::P_SIZE
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 pcInc,
    input  logic                 demoSwitch,
`ifdef PC_BRANCH_EN
    input  logic                 branchEn,
    input  logic [P_SIZE-1:0]    branchOffset,
`endif
    output logic [P_SIZE-1:0]    pcAddr,
    output logic                 stalled,
    output logic                 swPress,
    output cpuConfig::pc_debug_t dbg
);

    import cpuConfig::pcState_t;
    import cpuConfig::RUN;
    import cpuConfig::STALL;

    pcState_t          state;
    logic              sw_level;
    logic              sw_rise;
    logic [P_SIZE-1:0] next_addr;

    switch_sync u_switch_sync (
        .clk    (clk),
        .nReset (nReset),
        .raw    (demoSwitch),
        .level  (sw_level),
        .rise   (sw_rise)
    );

    // Address loaded whenever the decoder advances; wraps modulo 2^P_SIZE.
    always_comb begin
        next_addr = pcAddr + P_SIZE'(1);
`ifdef PC_BRANCH_EN
        // Offset is two's complement at full width, so a plain add sign-extends.
        if (branchEn) begin
            next_addr = pcAddr + branchOffset;
        end
`endif
    end

    // Sequencer: advance or stall; latch a switch press only while stalled.
    // Leaving STALL clears swPress even if a new edge arrives on the same cycle.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state   <= RUN;
            pcAddr  <= '0;
            swPress <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // Edges seen while running are dropped so they cannot
                    // release a stall that has not happened yet.
                    swPress <= 1'b0;
                    if (pcInc) begin
                        pcAddr <= next_addr;
                    end else begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (pcInc) begin
                        pcAddr  <= next_addr;
                        state   <= RUN;
                        swPress <= 1'b0;
                    end else if (sw_rise) begin
                        swPress <= 1'b1;
                    end
                end
                default: begin
                    state   <= RUN;
                    swPress <= 1'b0;
                end
            endcase
        end
    end

    assign stalled      = (state == STALL);
    assign dbg.state    = state;
    assign dbg.sw_level = sw_level;
    assign dbg.sw_rise  = sw_rise;

endmodule
